// File: rtl/noc_pkg.sv
// Shared router definitions: port codes (same encoding as the 1-to-5 demux
// select), port count, default flit width and the merge FSM state type.
package noc_pkg;

  localparam int NP     = 5;
  localparam int DW_DEF = 64;

  localparam logic [2:0] PORT_0 = 3'd0;
  localparam logic [2:0] PORT_1 = 3'd1;
  localparam logic [2:0] PORT_2 = 3'd2;
  localparam logic [2:0] PORT_3 = 3'd3;
  localparam logic [2:0] PORT_4 = 3'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } merge_state_e;

  // (p + k) mod 5 for port codes; both operands are 0..4.
  function automatic logic [2:0] port_add(input logic [2:0] p, input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s > {1'b0, PORT_4}) s = s - 4'd5;
    return s[2:0];
  endfunction

endpackage

// File: rtl/port_merge5to1_if.sv
// Flit bundle between the five input channels, the merge stage and the
// single output channel. master = traffic source/sink, slave = merge block.
interface port_merge5to1_if
  import noc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NP = noc_pkg::NP
);

  logic [NP-1:0]    in_valid;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]    in_head;
  logic [NP-1:0]    in_tail;
  logic [NP-1:0]    in_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_head;
  logic             out_tail;
  logic [2:0]       out_src;
  logic             out_ready;

  modport master (
    output in_valid, in_data, in_head, in_tail, out_ready,
    input  in_ready, out_valid, out_data, out_head, out_tail, out_src
  );

  modport slave (
    input  in_valid, in_data, in_head, in_tail, out_ready,
    output in_ready, out_valid, out_data, out_head, out_tail, out_src
  );

endinterface

// File: rtl/rr_arb5.sv
// Five-way round-robin pick: first requester scanning ptr, ptr+1, ... mod 5.
// Purely combinational; the pointer register lives in the parent.
module rr_arb5
  import noc_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic       gnt_vld,
  output logic [2:0] gnt_idx
);

  logic [2:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = PORT_0;
    idx     = PORT_0;
    for (int k = 4; k >= 0; k--) begin
      idx = port_add(ptr, 3'(k));
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/port_merge5to1.sv
// Output-side merge of five flit channels into one: round-robin head
// arbitration, packet lock until tail, single registered output stage.
module port_merge5to1
  import noc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NP = noc_pkg::NP
)(
  input  logic               clk,
  input  logic               reset,
  port_merge5to1_if.slave    bus
);

  merge_state_e  state_q;
  logic [2:0]    ptr_q;
  logic [2:0]    lk_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          out_head_q;
  logic          out_tail_q;
  logic [2:0]    out_src_q;

  logic          ld;
  logic [4:0]    req;
  logic          gnt_vld;
  logic [2:0]    gnt_idx;
  logic [2:0]    sel;
  logic          sel_vld;
  logic [NP-1:0] rdy;
  logic [DW-1:0] sel_data;
  logic          sel_head;
  logic          sel_tail;
  logic          xfer;

  assign ld  = ~out_valid_q | bus.out_ready;
  // Only heads compete, and only while no packet holds the output.
  assign req = (state_q == ST_IDLE) ? 5'(bus.in_valid & bus.in_head) : 5'b0;

  rr_arb5 u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Select the active port (arbiter winner or locked port) and mux its flit.
  always_comb begin
    sel      = (state_q == ST_IDLE) ? gnt_idx : lk_q;
    sel_vld  = (state_q == ST_IDLE) ? gnt_vld : 1'b1;
    rdy      = '0;
    sel_data = '0;
    sel_head = 1'b0;
    sel_tail = 1'b0;
    xfer     = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (sel == 3'(i)) begin
        rdy[i]   = sel_vld & ld & ~reset;
        sel_data = bus.in_data[i*DW +: DW];
        sel_head = bus.in_head[i];
        sel_tail = bus.in_tail[i];
        xfer     = sel_vld & ld & ~reset & bus.in_valid[i];
      end
    end
  end

  assign bus.in_ready = rdy;

  // FSM, lock/pointer registers and the output register in one process.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PORT_0;
      lk_q        <= PORT_0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_head_q  <= 1'b0;
      out_tail_q  <= 1'b0;
      out_src_q   <= PORT_0;
    end else begin
      if (ld) out_valid_q <= xfer;
      if (xfer) begin
        out_data_q <= sel_data;
        out_head_q <= sel_head;
        out_tail_q <= sel_tail;
        out_src_q  <= sel;
        case (state_q)
          ST_IDLE: begin
            if (!sel_tail) begin
              state_q <= ST_LOCKED;
              lk_q    <= sel;
            end else begin
              ptr_q <= port_add(sel, 3'd1);
            end
          end
          ST_LOCKED: begin
            if (sel_tail) begin
              state_q <= ST_IDLE;
              ptr_q   <= port_add(lk_q, 3'd1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_head  = out_head_q;
  assign bus.out_tail  = out_tail_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_port_merge5to1.sv
// Directed bench for port_merge5to1: reset, rotation, packet lock,
// backpressure, pointer wrap/skip, reset mid-packet with a stray body flit.
module tb_port_merge5to1;
  import noc_pkg::*;

  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  port_merge5to1_if #(.DW(DW), .NP(NP)) bus ();

  port_merge5to1 #(.DW(DW), .NP(NP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pay(input int p, input int n);
    return {32'(p), 32'(n)};
  endfunction

  task automatic drv(input int p, input logic v, input logic h, input logic t,
                     input logic [DW-1:0] d);
    bus.in_valid[p]          = v;
    bus.in_head[p]           = h;
    bus.in_tail[p]           = t;
    bus.in_data[p*DW +: DW]  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int src, input logic [DW-1:0] d,
                         input logic h, input logic t);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_src"},   64'(bus.out_src),   64'(src));
    check({tag, "_data"},  bus.out_data,       d);
    check({tag, "_head"},  64'(bus.out_head),  64'(h));
    check({tag, "_tail"},  64'(bus.out_tail),  64'(t));
  endtask

  initial begin
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = '0;
    bus.in_head   = '0;
    bus.in_tail   = '0;
    bus.in_data   = '0;

    // Reset held 3 cycles with every port presenting a single-flit packet
    for (int p = 0; p < 5; p++) drv(p, 1'b1, 1'b1, 1'b1, pay(p, 0));
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  bus.out_data,       64'd0);
    check("rst_out_head",  64'(bus.out_head),  64'd0);
    check("rst_out_tail",  64'(bus.out_tail),  64'd0);
    check("rst_out_src",   64'(bus.out_src),   64'd0);

    // Single-flit rotation 0,1,2,3,4,0
    reset = 1'b0;
    #1;
    check("rot_first_ready", 64'(bus.in_ready), 64'b00001);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk_out("rot", k % 5, pay(k % 5, 0), 1'b1, 1'b1);
      if (k == 5) for (int p = 0; p < 5; p++) drv(p, 1'b0, 1'b0, 1'b0, '0);
      tick();
    end
    check("rot_idle_valid", 64'(bus.out_valid), 64'd0);

    // Packet lock: ptr=1, port 2 four-flit packet beats heads on 0 and 4
    drv(2, 1'b1, 1'b1, 1'b0, pay(2, 0));
    drv(0, 1'b1, 1'b1, 1'b1, pay(0, 9));
    drv(4, 1'b1, 1'b1, 1'b1, pay(4, 9));
    #1;
    check("lock_grant", 64'(bus.in_ready), 64'b00100);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk_out("lock", 2, pay(2, n), (n == 0), (n == 3));
      if (n < 3) drv(2, 1'b1, 1'b0, (n + 1 == 3), pay(2, n + 1));
      else       drv(2, 1'b0, 1'b0, 1'b0, '0);
      if (n == 0) begin
        #1;
        check("lock_hold_ready", 64'(bus.in_ready), 64'b00100);
      end
    end
    tick();
    chk_out("after_lock_p4", 4, pay(4, 9), 1'b1, 1'b1);
    drv(4, 1'b0, 1'b0, 1'b0, '0);
    tick();
    chk_out("after_lock_p0", 0, pay(0, 9), 1'b1, 1'b1);
    drv(0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check("lock_idle_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure mid-packet on port 1 (ptr=1)
    drv(1, 1'b1, 1'b1, 1'b0, pay(1, 0));
    tick();
    chk_out("bp_f0", 1, pay(1, 0), 1'b1, 1'b0);
    drv(1, 1'b1, 1'b0, 1'b0, pay(1, 1));
    tick();
    chk_out("bp_f1", 1, pay(1, 1), 1'b0, 1'b0);
    drv(1, 1'b1, 1'b0, 1'b0, pay(1, 2));
    bus.out_ready = 1'b0;
    #1;
    check("bp_ready0", 64'(bus.in_ready), 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_out("bp_hold", 1, pay(1, 1), 1'b0, 1'b0);
      check("bp_hold_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'b00010);
    tick();
    chk_out("bp_f2", 1, pay(1, 2), 1'b0, 1'b0);
    drv(1, 1'b1, 1'b0, 1'b1, pay(1, 3));
    tick();
    chk_out("bp_f3", 1, pay(1, 3), 1'b0, 1'b1);
    drv(1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check("bp_idle_valid", 64'(bus.out_valid), 64'd0);

    // Wrap and skip: ptr=2 -> port 3 sets ptr=4; port 1 alone wins; ptr=2
    drv(3, 1'b1, 1'b1, 1'b1, pay(3, 5));
    tick();
    chk_out("wrap_p3", 3, pay(3, 5), 1'b1, 1'b1);
    drv(3, 1'b0, 1'b0, 1'b0, '0);
    drv(1, 1'b1, 1'b1, 1'b1, pay(1, 5));
    #1;
    check("wrap_grant1", 64'(bus.in_ready), 64'b00010);
    tick();
    chk_out("wrap_p1", 1, pay(1, 5), 1'b1, 1'b1);
    drv(1, 1'b0, 1'b0, 1'b0, '0);
    drv(3, 1'b1, 1'b1, 1'b1, pay(3, 6));
    drv(0, 1'b1, 1'b1, 1'b1, pay(0, 6));
    #1;
    check("skip_grant3", 64'(bus.in_ready), 64'b01000);
    tick();
    chk_out("skip_p3", 3, pay(3, 6), 1'b1, 1'b1);
    drv(3, 1'b0, 1'b0, 1'b0, '0);
    tick();
    chk_out("skip_p0", 0, pay(0, 6), 1'b1, 1'b1);
    drv(0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check("skip_idle_valid", 64'(bus.out_valid), 64'd0);

    // Reset during a locked port 3 packet, then a stray body flit
    drv(3, 1'b1, 1'b1, 1'b0, pay(3, 7));
    tick();
    chk_out("mid_head", 3, pay(3, 7), 1'b1, 1'b0);
    drv(3, 1'b1, 1'b0, 1'b0, pay(3, 8));
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stray_ready", 64'(bus.in_ready), 64'd0);
      tick();
      check("stray_valid", 64'(bus.out_valid), 64'd0);
    end
    drv(0, 1'b1, 1'b1, 1'b1, pay(0, 7));
    #1;
    check("post_rst_grant", 64'(bus.in_ready), 64'b00001);
    tick();
    chk_out("post_rst_p0", 0, pay(0, 7), 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/port_merge5to1.md
# port_merge5to1

Output-side merge stage of the router: combines five input flit channels into one output channel, the reverse of the 1-to-5 port demux that fans a flit out by 3-bit port select. Grants are round-robin and packet-locked: once a head flit wins, only that input is forwarded until its tail flit passes. The output is a single registered stage with valid/ready handshake, and the winning source is reported as a 3-bit port code with the same encoding as the demux select.

## Interface
- `DW`, default 64: flit payload width in bits.
- `NP`, default 5: number of input ports. Fixed at 5; the parameter exists only for package consistency.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  5  per-port flit valid; bit i is port i.
- `in_data`  in  5*DW  port i payload in bits `[i*DW +: DW]`.
- `in_head`  in  5  flit is the first flit of a packet.
- `in_tail`  in  5  flit is the last flit of a packet. Head and tail both set means a single-flit packet.
- `in_ready`  out  5  per-port accept. A transfer happens on port i when `in_valid[i] & in_ready[i]`.
- `out_valid`  out  1  output register holds a flit.
- `out_data`  out  DW  registered payload.
- `out_head`  out  1  registered head flag.
- `out_tail`  out  1  registered tail flag.
- `out_src`  out  3  source port code, 3'b000..3'b100 for ports 0..4; the same code as the demux `sel`.
- `out_ready`  in  1  downstream accepts; an output transfer happens on `out_valid & out_ready`.

## Operation
- **State machine:** IDLE and LOCKED, plus a 3-bit lock register `lk` and a round-robin pointer `ptr` (0..4).
- **Load enable:** `ld = ~out_valid | out_ready`. The output register loads only when `ld` is true.
- **IDLE:**
  - Candidates are ports with `in_valid & in_head`.
  - The winner `g` is the first candidate scanning `ptr, ptr+1, …` mod 5.
  - `in_ready[g] = ld`; all other `in_ready` bits are 0.
  - A valid non-head flit presented in IDLE is never granted, which stalls that port. This is a protocol error and is not otherwise flagged.
- **On head transfer from g:**
  - The flit loads into the output register and `out_src` is set to g.
  - If tail=0: go to LOCKED and set `lk=g`.
  - If tail=1: stay in IDLE and set `ptr=(g+1) mod 5`.
- **LOCKED:**
  - `in_ready[lk] = ld`; all other bits are 0. The head flag on incoming flits is ignored.
  - On the tail transfer: go to IDLE and set `ptr=(lk+1) mod 5`.
- **Pointer:** `ptr` wraps 4→0. It changes only on tail transfers.
- **Output register:**
  - When `ld` is true and an input transfer occurs, the register loads and `out_valid` becomes 1.
  - When `ld` is true and no input transfer occurs, `out_valid` becomes 0.
  - When `ld` is false, the register holds and all fields stay stable.
- **Flag passthrough:** `out_head` and `out_tail` are copied verbatim from the input flags.

## Timing
- **Reset values (after a clock edge with `reset=1`):** state=IDLE, `ptr`=0, `lk`=0, `out_valid`=0, `out_data`=0, `out_head`=0, `out_tail`=0, `out_src`=0.
- **`in_ready` during reset:** `in_ready`=0 in every cycle where `reset` is asserted. It is combinational, gated by `~reset`.
- **Latency:** 1 cycle, from an input transfer to `out_valid` on the next edge.
- **Throughput:** 1 flit per cycle when `out_ready` is held high.
- **Tail-to-head hand-off:** a tail transfer at edge t allows a new head grant in cycle t+1, so there is no bubble between packets.
- **Backpressure:** when `out_valid=1` and `out_ready=0`, all `in_ready` bits are 0 and the output fields hold.
- **Simultaneous load and drain:** with `out_valid & out_ready` and an input transfer in the same cycle, the register is replaced, with no loss and no duplication.
- **No combinational through-path:** `in_ready` depends on `out_ready` combinationally (through `ld`), but there is no path from `in_*` to `out_*`.
- **Reset mid-packet:**
  - The lock is dropped and `out_valid` clears at that edge.
  - The partial packet is truncated. Downstream recovery is outside this block.
- **All-request case:** when all five ports request continuously with single-flit packets, grants rotate 0,1,2,3,4,0…

## Structure
- **Shared router package** `noc_pkg` holds:
  - The port codes `PORT_0..PORT_4 = 3'd0..3'd4`, shared with the demux select encoding.
  - `NP = 5`.
  - The `DW` default.
- **Sub-module `rr_arb5`:**
  - Inputs: `req[4:0]`, `ptr[2:0]`.
  - Outputs: `gnt_vld`, `gnt_idx[2:0]`.
  - Purely combinational; the pointer register stays in the parent.
- **Parent block (120–250 lines):** FSM, lock and pointer registers, input mux, output register.

## Test plan
- **Reset:** hold `reset` for 3 cycles with all inputs valid.
  - Required: `in_ready`=0 throughout; all outputs 0 after the reset edge.
- **Single-flit rotation:** ports 0–4 all present head=tail=1 continuously with `out_ready`=1.
  - Required: `out_src` sequence 0,1,2,3,4,0 on consecutive cycles, each `out_data` matching its source.
- **Packet lock:**
  - Port 2 sends a 4-flit packet while port 0 and port 4 present heads.
  - Required: four consecutive outputs with `out_src`=2 (head on the first, tail on the last).
  - Required: the next grant goes to port 4, then port 0.
- **Backpressure:**
  - Drop `out_ready` for 5 cycles in mid-packet.
  - Required: output fields stable, `in_ready`=00000.
  - Required: on release, the flits resume in order with none dropped or duplicated.
- **Wrap and skip:**
  - With `ptr`=4 and only port 1 requesting, port 1 is granted.
  - After its tail, `ptr`=2; port 3 then requests and is granted within 1 cycle.
- **Reset mid-packet and stray body flit:**
  - Assert `reset` during a locked port 3 packet.
  - Required: `out_valid`=0 and state IDLE after the reset edge.
  - Required: a subsequent body flit (head=0) presented on port 3 is never granted.
